// File: rtl/cpu_pkg.sv
// Shared definitions for the cpu_core_p single-cycle core.
//   - opcode constants for the 8-bit OP field
//   - ALU operation select enumeration used between decode and alu_p
//   - bit positions of the instruction fields inside the 32-bit word
//   - helper that tells whether an opcode is defined
package cpu_pkg;

  // Opcode map (OP field, INS[31:24])
  localparam logic [7:0] OP_ADD   = 8'd0;
  localparam logic [7:0] OP_SUB   = 8'd1;
  localparam logic [7:0] OP_AND   = 8'd2;
  localparam logic [7:0] OP_OR    = 8'd3;
  localparam logic [7:0] OP_MOV   = 8'd4;
  localparam logic [7:0] OP_LOADI = 8'd5;
  localparam logic [7:0] OP_J     = 8'd6;
  localparam logic [7:0] OP_BEQ   = 8'd7;
  localparam logic [7:0] OP_BNE   = 8'd8;
  localparam logic [7:0] OP_SLL   = 8'd9;
  localparam logic [7:0] OP_SRL   = 8'd10;

  // ALU operation select
  typedef enum logic [2:0] {
    ADD  = 3'd0,
    SUB  = 3'd1,
    AND  = 3'd2,
    OR   = 3'd3,
    PASS = 3'd4,
    SLL  = 3'd5,
    SRL  = 3'd6
  } alu_sel_e;

  // Instruction field positions: {OP, DEST, SRC1, SRC2/IMM}
  localparam int OP_MSB   = 31;
  localparam int OP_LSB   = 24;
  localparam int DEST_MSB = 23;
  localparam int DEST_LSB = 16;
  localparam int SRC1_MSB = 15;
  localparam int SRC1_LSB = 8;
  localparam int SRC2_MSB = 7;
  localparam int SRC2_LSB = 0;

  // Opcodes 11..255 are undefined.
  function automatic logic is_defined_op(input logic [7:0] op);
    return (op <= OP_SRL);
  endfunction

endpackage

// File: rtl/alu_p.sv
// Combinational ALU for cpu_core_p.
// Ports:
//   a, b    : operands (b is the passed-through value for PASS)
//   sel     : operation select (cpu_pkg::alu_sel_e)
//   shamt   : shift amount for SLL/SRL (IMM[4:0])
//   result  : operation result, modulo 2**DATA_W
//   eq      : high when a == b (used for beq/bne)
module alu_p
  import cpu_pkg::*;
#(
  parameter int DATA_W = 8
) (
  input  logic [DATA_W-1:0] a,
  input  logic [DATA_W-1:0] b,
  input  alu_sel_e          sel,
  input  logic [4:0]        shamt,
  output logic [DATA_W-1:0] result,
  output logic              eq
);

  // A shift of DATA_W or more positions clears the whole word.
  logic shift_all_out;
  assign shift_all_out = ({27'd0, shamt} >= 32'(DATA_W));

  always_comb begin
    result = '0;
    unique case (sel)
      ADD:     result = a + b;
      // Two's complement subtract; the carry out is dropped by the width.
      SUB:     result = a + ~b + DATA_W'(1);
      AND:     result = a & b;
      OR:      result = a | b;
      PASS:    result = b;
      SLL:     result = shift_all_out ? '0 : (a << shamt);
      SRL:     result = shift_all_out ? '0 : (a >> shamt);
      default: result = '0;
    endcase
  end

  assign eq = (a == b);

endmodule

// File: rtl/cpu_core_p.sv
// Single-cycle core: decode, register file and PC logic; arithmetic in alu_p.
// Every accepted instruction (INS_VALID = 1) completes on one rising edge:
// register write, PC update and the sticky ILLEGAL flag change together.
// INS_VALID = 0 is a fetch stall and freezes all architectural state.
// Ports:
//   CLK       : clock, all state changes on the rising edge
//   RESET     : asynchronous active-low reset (PC, registers, ILLEGAL -> 0)
//   INS       : instruction word {OP, DEST, SRC1, SRC2/IMM}
//   INS_VALID : INS belongs to the current PC
//   PC        : registered address of the instruction being executed
//   ILLEGAL   : registered, sticky undefined-opcode flag
module cpu_core_p
  import cpu_pkg::*;
#(
  parameter int DATA_W = 8,
  parameter int REG_AW = 3,
  parameter int PC_W   = 8
) (
  input  logic            CLK,
  input  logic            RESET,
  input  logic [31:0]     INS,
  input  logic            INS_VALID,
  output logic [PC_W-1:0] PC,
  output logic            ILLEGAL
);

  localparam int NUM_REGS = 1 << REG_AW;

  // Register file; read combinationally, written on the rising edge.
  logic [DATA_W-1:0] regs [NUM_REGS];

  // Instruction fields
  logic [7:0]        op;
  logic [7:0]        dest;
  logic [7:0]        imm;
  logic [REG_AW-1:0] rd;
  logic [REG_AW-1:0] rs1;
  logic [REG_AW-1:0] rs2;

  assign op   = INS[OP_MSB:OP_LSB];
  assign dest = INS[DEST_MSB:DEST_LSB];
  assign imm  = INS[SRC2_MSB:SRC2_LSB];
  // Only the low REG_AW bits of each register field select a register.
  assign rd   = INS[DEST_LSB +: REG_AW];
  assign rs1  = INS[SRC1_LSB +: REG_AW];
  assign rs2  = INS[SRC2_LSB +: REG_AW];

  // Upper bits of SRC1 are never used by any opcode.
  logic unused_ins_bits;
  assign unused_ins_bits = ^INS;

  // Operand reads see the contents before this edge's write, so
  // DEST = SRC1 naturally uses the old value.
  logic [DATA_W-1:0] rs1_val;
  logic [DATA_W-1:0] rs2_val;
  assign rs1_val = regs[rs1];
  assign rs2_val = regs[rs2];

  // Immediate and branch offset are both sign-extended from 8 bits.
  logic [DATA_W-1:0] imm_ext;
  logic [PC_W-1:0]   pc_plus4;
  logic [PC_W-1:0]   pc_target;
  assign imm_ext   = DATA_W'($signed(imm));
  assign pc_plus4  = PC + PC_W'(4);
  assign pc_target = pc_plus4 + (PC_W'($signed(dest)) << 2);

  // ALU
  alu_sel_e          alu_sel;
  logic [DATA_W-1:0] alu_result;
  logic              alu_eq;

  alu_p #(
    .DATA_W (DATA_W)
  ) u_alu (
    .a      (rs1_val),
    .b      (rs2_val),
    .sel    (alu_sel),
    .shamt  (imm[4:0]),
    .result (alu_result),
    .eq     (alu_eq)
  );

  // Decode
  logic              reg_we;
  logic [DATA_W-1:0] wdata;
  logic [PC_W-1:0]   pc_next;
  logic              illegal_op;

  always_comb begin
    alu_sel    = ADD;
    reg_we     = 1'b0;
    wdata      = alu_result;
    pc_next    = pc_plus4;
    illegal_op = !is_defined_op(op);
    case (op)
      OP_ADD: begin
        alu_sel = ADD;
        reg_we  = 1'b1;
      end
      OP_SUB: begin
        alu_sel = SUB;
        reg_we  = 1'b1;
      end
      OP_AND: begin
        alu_sel = AND;
        reg_we  = 1'b1;
      end
      OP_OR: begin
        alu_sel = OR;
        reg_we  = 1'b1;
      end
      OP_MOV: begin
        alu_sel = PASS;
        reg_we  = 1'b1;
      end
      OP_LOADI: begin
        reg_we = 1'b1;
        wdata  = imm_ext;
      end
      OP_J: begin
        pc_next = pc_target;
      end
      OP_BEQ: begin
        if (alu_eq) pc_next = pc_target;
      end
      OP_BNE: begin
        if (!alu_eq) pc_next = pc_target;
      end
      OP_SLL: begin
        alu_sel = SLL;
        reg_we  = 1'b1;
      end
      OP_SRL: begin
        alu_sel = SRL;
        reg_we  = 1'b1;
      end
      default: begin
        // Undefined opcode: behaves as a NOP that advances the PC.
        reg_we = 1'b0;
      end
    endcase
  end

  // State update. Reset is asynchronous, so an instruction in flight when
  // RESET falls is simply dropped.
  always_ff @(posedge CLK or negedge RESET) begin
    if (!RESET) begin
      PC      <= '0;
      ILLEGAL <= 1'b0;
      for (int i = 0; i < NUM_REGS; i++) begin
        regs[i] <= '0;
      end
    end else if (INS_VALID) begin
      PC <= pc_next;
      if (illegal_op) ILLEGAL <= 1'b1;
      if (reg_we) regs[rd] <= wdata;
    end
  end

endmodule
